// File: rtl/add_mp_seq.sv
`default_nettype none
// ============================================================================
// Module   : add_mp_seq
// Brief    : Multi-precision adder that reuses one 16-bit adder, one word
//            per cycle. Define ADD_MP_SUB_EN to enable subtraction (A-B).
// Revision : 1.0 - initial release
// ============================================================================

module add_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {16'b0, ci};

endmodule

module add_mp_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [16*WORDS-1:0]  op_a,
  input  logic [16*WORDS-1:0]  op_b,
  input  logic                 cyi,
  input  logic                 sub,
  output logic                 busy,
  output logic                 done,
  output logic [16*WORDS-1:0]  sum,
  output logic                 cyo
);

  localparam int IW = $clog2(WORDS);
  localparam int DW = 16 * WORDS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_sum;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic          r_cyo;
  logic          w_sub_eff;
  logic          w_last;
  logic [15:0]   w_a_word;
  logic [15:0]   w_b_word;
  logic [15:0]   w_s;
  logic          w_co;

`ifdef ADD_MP_SUB_EN
  assign w_sub_eff = sub;
`else
  // Subtract select has no effect in the add-only build.
  assign w_sub_eff = sub & 1'b0;
`endif

  assign w_last   = (r_idx == IW'(WORDS - 1));
  assign w_a_word = r_a[{r_idx, 4'b0000} +: 16];
  assign w_b_word = r_b[{r_idx, 4'b0000} +: 16];

  add_16 u_add (
    .a  (w_a_word),
    .b  (w_b_word),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_FIN:   begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Carry-out is captured on the last word so it equals the carry register in FIN
  // and then holds until the next accepted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cyo   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b ^ {DW{w_sub_eff}};
            r_carry <= w_sub_eff | cyi;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[{r_idx, 4'b0000} +: 16] <= w_s;
          r_carry <= w_co;
          if (w_last) r_cyo <= w_co;
          else        r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum = r_sum;
  assign cyo = r_cyo;

endmodule

`default_nettype wire

// File: tb/tb_add_mp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_mp_seq
// Brief    : Directed scoreboard bench for add_mp_seq with WORDS=4.
// Revision : 1.0 - initial release
// ============================================================================

module tb_add_mp_seq;

  localparam int WORDS = 4;
  localparam int DW    = 16 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          cyi;
  logic          sub;
  logic          busy;
  logic          done;
  logic [DW-1:0] sum;
  logic          cyo;

  int total = 0;
  int bad   = 0;
  logic [DW:0] sb_q[$];
  logic [DW:0] last_res;

  always #5 clk = ~clk;

  add_mp_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cyi   (cyi),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cyo   (cyo)
  );

  function automatic logic [DW:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic ci, input logic s);
`ifdef ADD_MP_SUB_EN
    if (s) return {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
`endif
    return {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, ci};
  endfunction

  task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  // Drive one request at a falling edge; the next rising edge accepts it.
  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic ci, input logic s);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; cyi = ci; sub = s;
    sb_q.push_back(model(a, b, ci, s));
  endtask

  task automatic pop_check(input string tag);
    logic [DW:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, {1'b0, sum}, {(DW+1){1'bx}});
    end else begin
      e = sb_q.pop_front();
      last_res = e;
      check({tag, "_sum"}, {1'b0, sum}, {1'b0, e[DW-1:0]});
      check({tag, "_cyo"}, {{DW{1'b0}}, cyo}, {{DW{1'b0}}, e[DW]});
    end
  endtask

  // Runs 12 cycles after start_op; inject=1 raises START again mid-run with other operands.
  task automatic finish_op(input string tag, input bit inject);
    int lat = -1;
    int busy_n = 0;
    int done_n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = k;
          pop_check(tag);
        end
      end
      if (inject && k == 2) begin
        start = 1'b1; op_a = rnd(); op_b = rnd(); cyi = 1'b1; sub = 1'b0;
      end else begin
        start = 1'b0; op_a = rnd(); op_b = rnd(); cyi = $urandom_range(0, 1); sub = 1'b0;
      end
    end
    check({tag, "_latency"}, DW'(lat), DW'(WORDS + 1));
    check({tag, "_busy_cycles"}, DW'(busy_n), DW'(WORDS + 1));
    check({tag, "_done_count"}, DW'(done_n), DW'(1));
    check({tag, "_hold_sum"}, {1'b0, sum}, {1'b0, last_res[DW-1:0]});
  endtask

  initial begin
    int done_n;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cyi = 1'b0; sub = 1'b0;
    last_res = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {{DW{1'b0}}, busy}, '0);
    check("rst_done", {{DW{1'b0}}, done}, '0);
    check("rst_sum", {1'b0, sum}, '0);
    check("rst_cyo", {{DW{1'b0}}, cyo}, '0);
    rst_n = 1'b1;

    // Single-word carry into word 1.
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    finish_op("carry_w0", 1'b0);

    // Carry ripples across every word.
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    finish_op("ripple", 1'b0);

    // Second START while busy must be ignored.
    start_op(64'h1111_1111_1111_1111, 64'h1234_1100_0000_1111, 1'b0, 1'b0);
    finish_op("busy_ignore", 1'b1);

    start_op(64'h5, 64'h7, 1'b0, 1'b1);
    finish_op("sub_sel", 1'b0);

    start_op(rnd(), rnd(), 1'b1, 1'b0);
    finish_op("random", 1'b0);

    // Back-to-back: START held high, accepts every WORDS+2 cycles.
    start_op(rnd(), rnd(), 1'b0, 1'b0);
    done_n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        check("b2b_done_phase", DW'(k % (WORDS + 2)), DW'(WORDS + 1));
        pop_check("b2b");
      end
      if (k == 6 || k == 12) begin
        op_a = rnd(); op_b = rnd(); cyi = $urandom_range(0, 1);
        sb_q.push_back(model(op_a, op_b, cyi, 1'b0));
      end else begin
        op_a = rnd(); op_b = rnd(); cyi = $urandom_range(0, 1);
      end
      if (k >= 17) start = 1'b0;
    end
    check("b2b_done_count", DW'(done_n), DW'(3));

    // Reset asserted while RUN is on word index 2.
    start_op(rnd(), rnd(), 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", {{DW{1'b0}}, busy}, '0);
    check("abort_done", {{DW{1'b0}}, done}, '0);
    check("abort_sum", {1'b0, sum}, '0);
    check("abort_cyo", {{DW{1'b0}}, cyo}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    done_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) done_n++;
    end
    check("abort_no_done", DW'(done_n), DW'(0));

    start_op(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
    finish_op("post_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
